// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - 8E1 UART receiver, 16x oversampled, selectable baud.
// Define UART_RX_MAJORITY_VOTE_EN to decide each bit by 2-of-3 vote over samples 7..9.
module uart_receiver #(
  parameter int CLK_FREQ   = 50000000,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] baud_select,
  input  logic       RX_EN,
  input  logic       RxD,
  output logic [7:0] Rx_DATA,
  output logic       Rx_VALID,
  output logic       Rx_PERROR,
  output logic       Rx_FERROR
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t      state;
  logic        meta, rx_sync, rx_prev;
  logic [2:0]  baud_lat;
  logic [13:0] tick_cnt;
  logic [13:0] div;
  logic [3:0]  sample_cnt;
  logic [2:0]  bit_cnt;
  logic [7:0]  shift_reg;
  logic        perr;
  logic        tick;
  logic        decide;
  logic        bit_val;

  function automatic logic [13:0] div_for(input logic [2:0] sel);
    int baud;
    case (sel)
      3'b000:  baud = 300;
      3'b001:  baud = 1200;
      3'b010:  baud = 4800;
      3'b011:  baud = 9600;
      3'b100:  baud = 19200;
      3'b101:  baud = 38400;
      3'b110:  baud = 57600;
      default: baud = 115200;
    endcase
    return 14'((CLK_FREQ + (OVERSAMPLE * baud) / 2) / (OVERSAMPLE * baud));
  endfunction

  assign div  = div_for(baud_lat);
  assign tick = (state != IDLE) && (tick_cnt == div - 14'd1);

`ifdef UART_RX_MAJORITY_VOTE_EN
  logic s7, s8;
  assign decide  = tick && (sample_cnt == 4'd8);
  assign bit_val = (s7 & s8) | (s7 & rx_sync) | (s8 & rx_sync);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s7 <= 1'b1;
      s8 <= 1'b1;
    end else if (tick) begin
      if (sample_cnt == 4'd6) s7 <= rx_sync;
      if (sample_cnt == 4'd7) s8 <= rx_sync;
    end
  end
`else
  assign decide  = tick && (sample_cnt == 4'd7);
  assign bit_val = rx_sync;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      meta       <= 1'b1;
      rx_sync    <= 1'b1;
      rx_prev    <= 1'b1;
      baud_lat   <= 3'b000;
      tick_cnt   <= '0;
      sample_cnt <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      perr       <= 1'b0;
      Rx_DATA    <= 8'h00;
      Rx_VALID   <= 1'b0;
      Rx_PERROR  <= 1'b0;
      Rx_FERROR  <= 1'b0;
    end else begin
      meta     <= RxD;
      rx_sync  <= meta;
      rx_prev  <= rx_sync;
      Rx_VALID <= 1'b0;

      if (state == IDLE || tick) tick_cnt <= '0;
      else                       tick_cnt <= tick_cnt + 14'd1;
      if (tick) sample_cnt <= sample_cnt + 4'd1;

      if (!RX_EN) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            // Falling edge on the synchronised line marks a start bit.
            if (rx_prev && !rx_sync) begin
              state      <= START;
              baud_lat   <= baud_select;
              sample_cnt <= '0;
            end
          end
          START: begin
            if (decide) begin
              bit_cnt <= '0;
              state   <= bit_val ? IDLE : DATA;
            end
          end
          DATA: begin
            if (decide) begin
              shift_reg <= {bit_val, shift_reg[7:1]};
              bit_cnt   <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) state <= PARITY;
            end
          end
          PARITY: begin
            if (decide) begin
              perr  <= bit_val ^ (^shift_reg);
              state <= STOP;
            end
          end
          STOP: begin
            if (decide) begin
              Rx_DATA   <= shift_reg;
              Rx_PERROR <= perr;
              Rx_FERROR <= ~bit_val;
              Rx_VALID  <= ~perr & bit_val;
              state     <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - scoreboard bench for uart_receiver with directed frames.
module tb_uart_receiver;

  localparam int D_FAST = 1;
  localparam int D_9600 = 12;
  localparam int D_SLOW = 384;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] baud_select;
  logic       RX_EN;
  logic       RxD;
  logic [7:0] Rx_DATA;
  logic       Rx_VALID;
  logic       Rx_PERROR;
  logic       Rx_FERROR;

  int         total = 0;
  int         bad = 0;
  int         pulse_cnt = 0;
  int         pulses_before;
  logic       prev_valid = 1'b0;
  logic [7:0] exp_q[$];

  uart_receiver #(.CLK_FREQ(1843200), .OVERSAMPLE(16)) dut (
    .clk(clk),
    .reset(reset),
    .baud_select(baud_select),
    .RX_EN(RX_EN),
    .RxD(RxD),
    .Rx_DATA(Rx_DATA),
    .Rx_VALID(Rx_VALID),
    .Rx_PERROR(Rx_PERROR),
    .Rx_FERROR(Rx_FERROR)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_bits(input logic [10:0] bits, input int n, input int div);
    for (int i = 0; i < n; i++) begin
      RxD = bits[i];
      repeat (16 * div) @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stp, input int div);
    send_bits({stp, par, d, 1'b0}, 11, div);
    RxD = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  // Monitor: every valid pulse is matched against the oldest expected byte.
  always @(negedge clk) begin
    if (reset && Rx_VALID) begin
      pulse_cnt++;
      check("valid_width", {31'd0, prev_valid}, 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_valid", {24'd0, Rx_DATA}, 32'hFFFF_FFFF);
      end else begin
        check("rx_word", {22'd0, Rx_DATA, Rx_PERROR, Rx_FERROR},
              {22'd0, exp_q.pop_front(), 1'b0, 1'b0});
      end
    end
    prev_valid <= Rx_VALID;
  end

  initial begin
    reset = 1'b0;
    RX_EN = 1'b1;
    RxD = 1'b1;
    baud_select = 3'b111;
    repeat (3) @(negedge clk);
    check("reset_data", {24'd0, Rx_DATA}, 32'h00);
    check("reset_valid", {31'd0, Rx_VALID}, 32'd0);
    check("reset_perr", {31'd0, Rx_PERROR}, 32'd0);
    check("reset_ferr", {31'd0, Rx_FERROR}, 32'd0);
    reset = 1'b1;
    repeat (5) @(negedge clk);

    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b0, 1'b1, D_FAST);
    check("basic_pulses", pulse_cnt, 1);

    baud_select = 3'b011;
    pulses_before = pulse_cnt;
    send_frame(8'hA7, 1'b0, 1'b1, D_9600);
    check("perr_no_pulse", pulse_cnt, pulses_before);
    check("perr_data", {24'd0, Rx_DATA}, 32'hA7);
    check("perr_flag", {31'd0, Rx_PERROR}, 32'd1);
    check("perr_ferr", {31'd0, Rx_FERROR}, 32'd0);

    baud_select = 3'b111;
    pulses_before = pulse_cnt;
    send_frame(8'h0F, 1'b0, 1'b0, D_FAST);
    check("ferr_no_pulse", pulse_cnt, pulses_before);
    check("ferr_data", {24'd0, Rx_DATA}, 32'h0F);
    check("ferr_flag", {31'd0, Rx_FERROR}, 32'd1);
    check("ferr_perr", {31'd0, Rx_PERROR}, 32'd0);
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b0, 1'b1, D_FAST);
    check("recover_ferr", {31'd0, Rx_FERROR}, 32'd0);
    check("recover_perr", {31'd0, Rx_PERROR}, 32'd0);

    pulses_before = pulse_cnt;
    RxD = 1'b0;
    repeat (4 * D_FAST) @(negedge clk);
    RxD = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_no_pulse", pulse_cnt, pulses_before);
    check("glitch_data_held", {24'd0, Rx_DATA}, 32'h3C);
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b0, 1'b1, D_FAST);

    exp_q.push_back(8'h01);
    exp_q.push_back(8'hFE);
    send_bits({1'b1, 1'b1, 8'h01, 1'b0}, 11, D_FAST);
    send_frame(8'hFE, 1'b1, 1'b1, D_FAST);
    baud_select = 3'b000;
    exp_q.push_back(8'hC3);
    send_frame(8'hC3, 1'b0, 1'b1, D_SLOW);
    check("b2b_data", {24'd0, Rx_DATA}, 32'hC3);

    baud_select = 3'b111;
    pulses_before = pulse_cnt;
    send_bits({1'b1, 1'b0, 8'h5A, 1'b0}, 5, D_FAST);
    RX_EN = 1'b0;
    RxD = 1'b1;
    repeat (200) @(negedge clk);
    RX_EN = 1'b1;
    repeat (20) @(negedge clk);
    check("disable_no_pulse", pulse_cnt, pulses_before);
    check("disable_data_held", {24'd0, Rx_DATA}, 32'hC3);
    exp_q.push_back(8'h96);
    send_frame(8'h96, 1'b0, 1'b1, D_FAST);

    send_bits({1'b1, 1'b0, 8'h33, 1'b0}, 4, D_FAST);
    reset = 1'b0;
    #1;
    check("midreset_data", {24'd0, Rx_DATA}, 32'h00);
    check("midreset_valid", {31'd0, Rx_VALID}, 32'd0);
    check("midreset_perr", {31'd0, Rx_PERROR}, 32'd0);
    check("midreset_ferr", {31'd0, Rx_FERROR}, 32'd0);
    RxD = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    repeat (200) @(negedge clk);

    check("total_pulses", pulse_cnt, 7);
    check("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
